mem2_stage: RTL and testbench
=============================

Name: mem2_stage

Overview:
- Second memory pipeline stage. Sits directly downstream of the MEM1 stage and upstream of WB.
- Registers the MEM1→MEM2 bus, which carries raw 64-bit SRAM read data plus control fields.
- Extracts and sign/zero-extends load data, selects the writeback value, and drives the WB bus and the ID forwarding path.
- Flags misaligned loads and keeps a 64-bit retired-instruction counter.

Parameters:
- MEM12MEM2_WD, 214, input bus width. Layout MSB→LSB: rdata[64], lsu_op[7], data_ram_sel[8], sel_rf_res[1], rf_we[1], rf_waddr[5], ex_result[64], pc[32], inst[32].
- MEM22WB_WD, 134, output bus width. Layout MSB→LSB: rf_we[1], rf_waddr[5], rf_wdata[64], pc[32], inst[32].
- MEM22ID_WD, 70, forwarding width. Layout MSB→LSB: rf_we[1], rf_waddr[5], rf_wdata[64].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush.
- stall  in  `StallBus  stall vector. This stage uses stall[5] (own) and stall[6] (downstream).
- mem12mem2_bus  in  MEM12MEM2_WD  from MEM1.
- mem22wb_bus  out  MEM22WB_WD  to WB.
- mem22id_fwd  out  MEM22ID_WD  forwarding to ID.
- load_misalign  out  1  registered-bus load is misaligned.
- instret  out  64  retired-instruction count.

Behaviour:
- Single clock domain. Reset is asynchronous, active-high. On rst: bus register = 0, instret = 0. All outputs are therefore 0 during reset.
- Register update priority at posedge clk (one action per edge, highest first):
  - flush → bus register cleared to 0.
  - stall[5] && !stall[6] → bus register cleared to 0 (bubble inserted).
  - !stall[5] → bus register loaded from mem12mem2_bus.
  - otherwise → bus register holds.
- Latency: 1 cycle from mem12mem2_bus to outputs. All outputs are combinational from the register.
- Bubble definition: inst == 0. A bubble produces all-zero outputs, because rf_we = 0 and every field is 0.
- lsu_op one-hot load encoding: bit0 lb, bit1 lbu, bit2 lh, bit3 lhu, bit4 lw, bit5 lwu, bit6 ld.
  - If more than one bit is set, priority is ld > lwu > lw > lhu > lh > lbu > lb.
- Byte offset is off = ex_result[2:0].
  - Byte loads: select rdata[8*off +: 8].
  - Half loads: select rdata[16*off[2:1] +: 16].
  - Word loads: select rdata[32*off[2] +: 32].
  - ld: select all 64 bits.
  - Signed ops sign-extend to 64 bits; unsigned ops zero-extend.
- Misalignment:
  - load_misalign = 1 when: a half op with off[0] != 0; a word op with off[1:0] != 0; ld with off != 0.
  - When misaligned, the rf_we output (WB and fwd) is forced to 0. Data fields are still driven.
- Writeback data: rf_wdata = extracted load data if sel_rf_res == 1, else ex_result.
- lsu_op == 0 with sel_rf_res == 1: rf_wdata = 0 and load_misalign = 0.
- rf_waddr == 0: passed through unchanged. x0 suppression belongs to the regfile.
- data_ram_sel is accepted but not used by this stage.
- instret:
  - Increments by 1 on each edge where the register loads (the !stall[5] branch) a bus whose inst field != 0.
  - Does not increment on flush, bubble insertion, or hold.
  - Wraps from 2^64-1 to 0.
- Reset asserted mid-operation clears the register and instret immediately (asynchronous). No outputs persist.
- Flush and stall asserted in the same cycle: flush wins.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs 0 and instret = 0 before the next edge. Deassert → outputs stay 0 until the first load.
- Byte loads: rdata = 0x8877_6655_4433_2281, ex_result = 0x1003 (off = 3), lb, sel_rf_res = 1, rf_we = 1, rf_waddr = 5.
  - Next cycle: rf_wdata = 0x0000_0000_0000_0044, fwd = {1, 5, same}.
  - Same with off = 7 and lb → 0xFFFF_FFFF_FFFF_FF88. With lbu → 0x88.
- Word/half/double: ex_result = 0x1004, lw → rf_wdata = 0xFFFF_FFFF_8877_6655. lwu → 0x8877_6655. ex_result = 0x1006, lh → 0xFFFF_FFFF_FFFF_8877. ld at off 0 → full 64-bit rdata.
- Misaligned: lw with ex_result = 0x1002 → load_misalign = 1, rf_we = 0 in both WB bus and fwd. An ALU op (sel_rf_res = 0, ex_result = 0x1234) → rf_wdata = 0x1234, load_misalign = 0.
- Stall/flush:
  - stall[5] = 1, stall[6] = 0 → next cycle outputs 0 and instret unchanged.
  - stall[5] = stall[6] = 1 → outputs hold.
  - flush together with !stall → cleared.
  - 3 valid loads plus 1 bubble → instret = 3.
- instret wrap: run a short instruction sequence across the 2^64-1 boundary (bench may force the counter) → after one more valid load, instret = 0.

Source files
------------

// File: rtl/mem2_stage_if.sv
// MEM1 -> MEM2 -> WB/ID bus bundle.
// master drives the MEM1 side, slave is the MEM2 stage.
interface mem2_stage_if #(
  parameter int MEM12MEM2_WD = 214,
  parameter int MEM22WB_WD   = 134,
  parameter int MEM22ID_WD   = 70
);
  logic [MEM12MEM2_WD-1:0] mem12mem2_bus;
  logic [MEM22WB_WD-1:0]   mem22wb_bus;
  logic [MEM22ID_WD-1:0]   mem22id_fwd;
  logic                    load_misalign;
  logic [63:0]             instret;

  modport master (
    output mem12mem2_bus,
    input  mem22wb_bus,
    input  mem22id_fwd,
    input  load_misalign,
    input  instret
  );

  modport slave (
    input  mem12mem2_bus,
    output mem22wb_bus,
    output mem22id_fwd,
    output load_misalign,
    output instret
  );
endinterface

// File: rtl/mem2_stage.sv
// MEM2 pipeline stage: load extraction, writeback select,
// misalign detection and retired-instruction counter.
module mem2_stage #(
  parameter int STALL_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  mem2_stage_if.slave        bus
);

  logic [213:0] r;
  logic [63:0]  instret_q;

  logic [63:0] rdata;
  logic [6:0]  lsu_op;
  logic [7:0]  data_ram_sel;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] ex_result;
  logic [31:0] pc;
  logic [31:0] inst;

  assign rdata        = r[213:150];
  assign lsu_op       = r[149:143];
  assign data_ram_sel = r[142:135];
  assign sel_rf_res   = r[134];
  assign rf_we        = r[133];
  assign rf_waddr     = r[132:128];
  assign ex_result    = r[127:64];
  assign pc           = r[63:32];
  assign inst         = r[31:0];

  logic bubble_ins;
  logic load_en;
  assign bubble_ins = stall[5] && !stall[6];
  assign load_en    = !flush && !stall[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else if (flush || bubble_ins) begin
      r <= '0;
    end else if (!stall[5]) begin
      r <= bus.mem12mem2_bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (load_en && bus.mem12mem2_bus[31:0] != 32'd0) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  logic [2:0]  off;
  logic [7:0]  b8;
  logic [15:0] h16;
  logic [31:0] w32;
  assign off = ex_result[2:0];
  assign b8  = rdata[{off, 3'b000} +: 8];
  assign h16 = rdata[{off[2:1], 4'b0000} +: 16];
  assign w32 = rdata[{off[2], 5'b00000} +: 32];

  logic [63:0] ld_data;
  logic        misalign;

  // multi-hot lsu_op resolves to the widest load
  always_comb begin
    ld_data  = '0;
    misalign = 1'b0;
    priority case (1'b1)
      lsu_op[6]: begin
        ld_data  = rdata;
        misalign = off != 3'd0;
      end
      lsu_op[5]: begin
        ld_data  = {32'd0, w32};
        misalign = off[1:0] != 2'd0;
      end
      lsu_op[4]: begin
        ld_data  = {{32{w32[31]}}, w32};
        misalign = off[1:0] != 2'd0;
      end
      lsu_op[3]: begin
        ld_data  = {48'd0, h16};
        misalign = off[0];
      end
      lsu_op[2]: begin
        ld_data  = {{48{h16[15]}}, h16};
        misalign = off[0];
      end
      lsu_op[1]: ld_data = {56'd0, b8};
      lsu_op[0]: ld_data = {{56{b8[7]}}, b8};
      default: begin
        ld_data  = '0;
        misalign = 1'b0;
      end
    endcase
  end

  logic        we_o;
  logic [63:0] wdata;
  assign we_o  = rf_we && !misalign;
  assign wdata = sel_rf_res ? ld_data : ex_result;

  assign bus.mem22wb_bus   = {we_o, rf_waddr, wdata, pc, inst};
  assign bus.mem22id_fwd   = {we_o, rf_waddr, wdata};
  assign bus.load_misalign = misalign;
  assign bus.instret       = instret_q;

  logic unused_ok;
  assign unused_ok = ^{data_ram_sel, stall[4:0]};

endmodule

// File: tb/tb_mem2_stage.sv
// Randomized and directed bench for mem2_stage with a
// shift-arithmetic reference model.
module tb_mem2_stage;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [6:0] stall;

  mem2_stage_if bus ();

  mem2_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nerr;

  logic [213:0] exp_reg;
  logic [63:0]  exp_ir;

  localparam logic [63:0] RD = 64'h8877_6655_4433_2281;

  function automatic logic [213:0] mk(
    input logic [63:0] rd, input logic [6:0] op,
    input logic sel, input logic we, input logic [4:0] wa,
    input logic [63:0] ex, input logic [31:0] inst);
    return {rd, op, 8'h5a, sel, we, wa, ex, 32'h0000_1000, inst};
  endfunction

  // Reference: fields pulled by shifting, sign handled by >>>
  task automatic model(input logic [213:0] m,
                       output logic [133:0] wb,
                       output logic [69:0] fwd,
                       output logic mis);
    logic [63:0] rd, ex, d;
    logic [6:0]  op;
    logic [2:0]  o;
    logic        we;
    int          sh;
    rd  = m[213:150];
    op  = m[149:143];
    ex  = m[127:64];
    o   = ex[2:0];
    d   = 64'd0;
    mis = 1'b0;
    if (op[6]) begin
      d = rd; mis = (o != 0);
    end else if (op[5] || op[4]) begin
      sh  = 32 - 32 * (o / 4);
      d   = op[5] ? (rd << sh) >> 32
                  : 64'($signed(rd << sh) >>> 32);
      mis = (o % 4) != 0;
    end else if (op[3] || op[2]) begin
      sh  = 48 - 16 * (o / 2);
      d   = op[3] ? (rd << sh) >> 48
                  : 64'($signed(rd << sh) >>> 48);
      mis = (o % 2) != 0;
    end else if (op[1] || op[0]) begin
      sh = 56 - 8 * o;
      d  = op[1] ? (rd << sh) >> 56
                 : 64'($signed(rd << sh) >>> 56);
    end
    we = m[133] & ~mis;
    if (!m[134]) d = ex;
    wb  = {we, m[132:128], d, m[63:0]};
    fwd = {we, m[132:128], d};
  endtask

  task automatic cyc(input logic [213:0] b, input logic fl,
                     input logic [6:0] st);
    bus.mem12mem2_bus = b;
    flush = fl;
    stall = st;
    @(posedge clk);
    if (fl) exp_reg = '0;
    else if (st[5] && !st[6]) exp_reg = '0;
    else if (!st[5]) begin
      exp_reg = b;
      if (b[31:0] != 0) exp_ir = exp_ir + 64'd1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_reg = '0;
    exp_ir = '0;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(mk(RD, 7'h10, 1, 1, 5'd7, 64'h1004, 32'h13), 0, 7'd0);
    #2;
    rst = 1'b1;
    exp_reg = '0;
    exp_ir = '0;
    #1;
    nchk++;
    if (bus.mem22wb_bus !== '0 || bus.mem22id_fwd !== '0 ||
        bus.load_misalign !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs wb=%h fwd=%h mis=%b want 0",
               bus.mem22wb_bus, bus.mem22id_fwd, bus.load_misalign);
    end
    nchk++;
    if (bus.instret !== 64'd0) begin
      nerr++;
      $display("FAIL reset_instret got=%h want 0", bus.instret);
    end
    rst = 1'b0;
    cyc(mk(RD, 7'h10, 1, 1, 5'd7, 64'h1004, 32'h13), 0, 7'h60);
    nchk++;
    if (bus.mem22wb_bus !== '0) begin
      nerr++;
      $display("FAIL post_reset_hold got=%h want 0", bus.mem22wb_bus);
    end
  endtask

  task automatic test_loads();
    logic [63:0] ex [6];
    logic [6:0]  op [6];
    logic [63:0] want [6];
    ex = '{64'h1003, 64'h1007, 64'h1007, 64'h1004,
           64'h1004, 64'h1006};
    op = '{7'h01, 7'h01, 7'h02, 7'h10, 7'h20, 7'h04};
    want = '{64'h44, 64'hFFFF_FFFF_FFFF_FF88, 64'h88,
             64'hFFFF_FFFF_8877_6655, 64'h8877_6655,
             64'hFFFF_FFFF_FFFF_8877};
    for (int i = 0; i < 6; i++) begin
      cyc(mk(RD, op[i], 1, 1, 5'd5, ex[i], 32'h3 + i), 0, 7'd0);
      nchk++;
      if (bus.mem22wb_bus[133:64] !== {1'b1, 5'd5, want[i]}) begin
        nerr++;
        $display("FAIL load%0d wb=%h want %h", i,
                 bus.mem22wb_bus[133:64], {1'b1, 5'd5, want[i]});
      end
      nchk++;
      if (bus.mem22id_fwd !== {1'b1, 5'd5, want[i]}) begin
        nerr++;
        $display("FAIL load%0d_fwd got=%h want %h", i,
                 bus.mem22id_fwd, {1'b1, 5'd5, want[i]});
      end
    end
    cyc(mk(RD, 7'h40, 1, 1, 5'd9, 64'h1000, 32'h77), 0, 7'd0);
    nchk++;
    if (bus.mem22id_fwd !== {1'b1, 5'd9, RD}) begin
      nerr++;
      $display("FAIL ld got=%h want %h", bus.mem22id_fwd,
               {1'b1, 5'd9, RD});
    end
  endtask

  task automatic test_misalign();
    cyc(mk(RD, 7'h10, 1, 1, 5'd5, 64'h1002, 32'h9), 0, 7'd0);
    nchk++;
    if (bus.load_misalign !== 1'b1 || bus.mem22wb_bus[133] !== 1'b0 ||
        bus.mem22id_fwd[69] !== 1'b0) begin
      nerr++;
      $display("FAIL misalign_lw mis=%b we=%b/%b want 1,0,0",
               bus.load_misalign, bus.mem22wb_bus[133],
               bus.mem22id_fwd[69]);
    end
    cyc(mk(RD, 7'h00, 0, 1, 5'd3, 64'h1234, 32'h33), 0, 7'd0);
    nchk++;
    if (bus.mem22id_fwd !== {1'b1, 5'd3, 64'h1234} ||
        bus.load_misalign !== 1'b0) begin
      nerr++;
      $display("FAIL alu_op fwd=%h mis=%b want %h,0", bus.mem22id_fwd,
               bus.load_misalign, {1'b1, 5'd3, 64'h1234});
    end
    cyc(mk(RD, 7'h00, 1, 1, 5'd0, 64'h1001, 32'h35), 0, 7'd0);
    nchk++;
    if (bus.mem22id_fwd !== {1'b1, 5'd0, 64'd0} ||
        bus.load_misalign !== 1'b0) begin
      nerr++;
      $display("FAIL no_op_load fwd=%h mis=%b want %h,0",
               bus.mem22id_fwd, bus.load_misalign, {1'b1, 5'd0, 64'd0});
    end
  endtask

  task automatic test_stall_flush();
    logic [213:0] y;
    logic [63:0]  ir0;
    y = mk(RD, 7'h02, 1, 1, 5'd4, 64'h1001, 32'h41);
    cyc(mk(RD, 7'h01, 1, 1, 5'd4, 64'h1000, 32'h40), 0, 7'd0);
    ir0 = bus.instret;
    cyc(y, 0, 7'h20);
    nchk++;
    if (bus.mem22wb_bus !== '0 || bus.instret !== ir0) begin
      nerr++;
      $display("FAIL bubble wb=%h ir=%h want 0,%h", bus.mem22wb_bus,
               bus.instret, ir0);
    end
    cyc(y, 0, 7'd0);
    cyc(mk(RD, 7'h40, 1, 1, 5'd8, 64'h0, 32'h55), 0, 7'h60);
    nchk++;
    if (bus.mem22wb_bus !== {1'b1, 5'd4, 64'h22, 32'h1000, 32'h41}) begin
      nerr++;
      $display("FAIL hold got=%h want %h", bus.mem22wb_bus,
               {1'b1, 5'd4, 64'h22, 32'h1000, 32'h41});
    end
    ir0 = bus.instret;
    cyc(y, 1, 7'd0);
    nchk++;
    if (bus.mem22wb_bus !== '0 || bus.instret !== ir0) begin
      nerr++;
      $display("FAIL flush wb=%h ir=%h want 0,%h", bus.mem22wb_bus,
               bus.instret, ir0);
    end
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(mk(RD, 7'h40, 1, 1, 5'd1, 64'h0, 32'h100 + i), 0, 7'd0);
    cyc('0, 0, 7'd0);
    nchk++;
    if (bus.instret !== 64'd3) begin
      nerr++;
      $display("FAIL instret_count got=%0d want 3", bus.instret);
    end
  endtask

  task automatic test_random();
    logic [213:0] b;
    logic [133:0] ewb;
    logic [69:0]  efwd;
    logic         emis;
    logic [6:0]   op, st;
    logic         fl;
    int           k;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      op = (k == 0) ? 7'd0 :
           (k == 1) ? 7'($urandom) : 7'(1 << $urandom_range(0, 6));
      b = {$urandom, $urandom, op, 8'($urandom), 1'($urandom),
           1'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b = '0;
      fl = ($urandom_range(0, 9) == 0);
      st = {1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 4) == 0), 5'($urandom)};
      cyc(b, fl, st);
      model(exp_reg, ewb, efwd, emis);
      nchk++;
      if (bus.mem22wb_bus !== ewb || bus.mem22id_fwd !== efwd ||
          bus.load_misalign !== emis) begin
        nerr++;
        $display("FAIL rand%0d wb=%h fwd=%h mis=%b want %h %h %b", i,
                 bus.mem22wb_bus, bus.mem22id_fwd, bus.load_misalign,
                 ewb, efwd, emis);
      end
      nchk++;
      if (bus.instret !== exp_ir) begin
        nerr++;
        $display("FAIL rand%0d_instret got=%h want %h", i,
                 bus.instret, exp_ir);
      end
    end
  endtask

  task automatic test_wrap();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    exp_ir = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc(mk(RD, 7'h40, 1, 1, 5'd2, 64'h0, 32'h61), 0, 7'd0);
    nchk++;
    if (bus.instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      nerr++;
      $display("FAIL wrap_max got=%h want ffffffffffffffff",
               bus.instret);
    end
    cyc(mk(RD, 7'h40, 1, 1, 5'd2, 64'h0, 32'h62), 0, 7'd0);
    nchk++;
    if (bus.instret !== 64'd0) begin
      nerr++;
      $display("FAIL wrap_zero got=%h want 0", bus.instret);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    flush = 1'b0;
    stall = '0;
    bus.mem12mem2_bus = '0;
    rst = 1'b0;
    #2;
    do_reset();
    @(negedge clk);
    test_reset();
    test_loads();
    test_misalign();
    test_stall_flush();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
